// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scanner: FSM states,
// display glyphs and their active-low segment patterns.
package seg_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

   typedef enum logic [3:0] {
      DIG0 = 4'd0, DIG1 = 4'd1, DIG2 = 4'd2, DIG3 = 4'd3, DIG4 = 4'd4,
      DIG5 = 4'd5, DIG6 = 4'd6, DIG7 = 4'd7, DIG8 = 4'd8, DIG9 = 4'd9,
      MINUS = 4'd10, LETTER_E = 4'd11, BLANK = 4'd12
   } glyph_t;

   localparam int MAX_POS_DEFAULT = 9999;
   localparam int MIN_NEG_DEFAULT = -999;
   localparam int BCD_STEPS       = 14;

   // {g,f,e,d,c,b,a}, a segment lights when its bit is 0
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] glyph_to_seg(input glyph_t g);
      case (g)
         DIG0:     return SEG_0;
         DIG1:     return SEG_1;
         DIG2:     return SEG_2;
         DIG3:     return SEG_3;
         DIG4:     return SEG_4;
         DIG5:     return SEG_5;
         DIG6:     return SEG_6;
         DIG7:     return SEG_7;
         DIG8:     return SEG_8;
         DIG9:     return SEG_9;
         MINUS:    return SEG_MINUS;
         LETTER_E: return SEG_E;
         default:  return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential 14-bit double-dabble: one add-3/shift step per cycle after start.
// done marks the cycle of the last shift, so bcd is final on the next cycle.
module bcd_converter
   import seg_pkg::*;
(
   input  logic        in_clk,
   input  logic        reset,
   input  logic        start,
   input  logic [13:0] mag,
   output logic        done,
   output logic [15:0] bcd
);

   logic [13:0] sh;
   logic [3:0]  cnt;
   logic [15:0] adj;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < 4; i++)
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
   end

   assign done = (cnt == 4'd1);

   always_ff @(posedge in_clk or posedge reset) begin
      if (reset) begin
         sh  <= '0;
         bcd <= '0;
         cnt <= '0;
      end else if (start) begin
         sh  <= mag;
         bcd <= '0;
         cnt <= 4'(BCD_STEPS);
      end else if (cnt != 4'd0) begin
         {bcd, sh} <= {adj, sh} << 1;
         cnt       <= cnt - 4'd1;
      end
   end

endmodule

// File: rtl/seg_display_scanner.sv
// Signed value to 4-digit common-anode display: conversion FSM, glyph/sign
// placement and a free-running one-digit-per-cycle scanner.
module seg_display_scanner
   import seg_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int MAX_POS = MAX_POS_DEFAULT,
   parameter int MIN_NEG = MIN_NEG_DEFAULT
) (
   input  logic                     in_clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] value,
   output logic [6:0]               seg,
   output logic [3:0]               an,
   output logic                     dp,
   output logic                     busy
);

   localparam logic signed [DATA_W-1:0] HI = DATA_W'(MAX_POS);
   localparam logic signed [DATA_W-1:0] LO = DATA_W'(MIN_NEG);

   state_t                   state;
   logic                     first, neg, err;
   logic signed [DATA_W-1:0] last_val;
   glyph_t                   disp [4];
   glyph_t                   nxt  [4];
   logic [1:0]               digit_sel;
   logic                     start, done;
   logic [13:0]              mag;
   logic [15:0]              bcd;
   logic                     b1, b2, b3;

   assign dp    = 1'b1;
   assign start = (state == LOAD);
   // Low 14 bits of |value|; anything wider is out of range and flagged by err.
   assign mag   = (value[13:0] ^ {14{value[DATA_W-1]}}) + 14'(value[DATA_W-1]);

   bcd_converter u_bcd (
      .in_clk (in_clk),
      .reset  (reset),
      .start  (start),
      .mag    (mag),
      .done   (done),
      .bcd    (bcd)
   );

   always_comb begin
      b3 = (bcd[15:12] == 4'd0);
      b2 = b3 && (bcd[11:8] == 4'd0);
      b1 = b2 && (bcd[7:4] == 4'd0);
      nxt[0] = glyph_t'(bcd[3:0]);
      nxt[1] = b1 ? BLANK : glyph_t'(bcd[7:4]);
      nxt[2] = b2 ? BLANK : glyph_t'(bcd[11:8]);
      nxt[3] = b3 ? BLANK : glyph_t'(bcd[15:12]);
      if (neg) begin
         if (b1)      nxt[1] = MINUS;
         else if (b2) nxt[2] = MINUS;
         else         nxt[3] = MINUS;
      end
      if (err) begin
         nxt[3] = LETTER_E;
         nxt[2] = MINUS;
         nxt[1] = MINUS;
         nxt[0] = MINUS;
      end
   end

   always_ff @(posedge in_clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         first    <= 1'b1;
         busy     <= 1'b0;
         last_val <= '0;
         neg      <= 1'b0;
         err      <= 1'b0;
         for (int i = 0; i < 4; i++) disp[i] <= BLANK;
      end else begin
         case (state)
            IDLE: if (first || value != last_val) begin
               state <= LOAD;
               busy  <= 1'b1;
            end
            LOAD: begin
               last_val <= value;
               first    <= 1'b0;
               neg      <= value[DATA_W-1];
               err      <= (value > HI) || (value < LO);
               state    <= CONV;
            end
            CONV: if (done) state <= DONE;
            DONE: begin
               disp  <= nxt;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge in_clk or posedge reset) begin
      if (reset) begin
         digit_sel <= 2'd0;
         an        <= 4'b1111;
         seg       <= SEG_BLANK;
      end else begin
         an        <= ~(4'b0001 << digit_sel);
         seg       <= glyph_to_seg(disp[digit_sel]);
         digit_sel <= digit_sel + 2'd1;
      end
   end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench: reset state, several values through a full scan, busy
// width, value change mid-conversion and reset mid-conversion.
module tb_seg_display_scanner;

   logic               in_clk = 1'b0;
   logic               reset;
   logic signed [15:0] value;
   logic [6:0]         seg;
   logic [3:0]         an;
   logic               dp, busy;
   int                 n_run = 0;
   int                 n_fail = 0;

   localparam logic [6:0] BL = 7'h7F, MI = 7'h3F, EE = 7'h06;
   localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D2 = 7'h24, D3 = 7'h30, D4 = 7'h19;
   localparam logic [6:0] D7 = 7'h78, D9 = 7'h10;

   seg_display_scanner dut (
      .in_clk (in_clk),
      .reset  (reset),
      .value  (value),
      .seg    (seg),
      .an     (an),
      .dp     (dp),
      .busy   (busy)
   );

   always #5 in_clk = ~in_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int an_idx(input logic [3:0] a);
      case (a)
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return 0;
      endcase
   endfunction

   task automatic scan(input string tag, input logic [6:0] e3, e2, e1, e0);
      logic [6:0] e [4];
      e = '{e0, e1, e2, e3};
      for (int k = 0; k < 4; k++) begin
         @(negedge in_clk);
         chk({tag, "_an"}, $countones(~an), 1);
         chk($sformatf("%s_d%0d", tag, an_idx(an)), {25'd0, seg}, {25'd0, e[an_idx(an)]});
      end
   endtask

   task automatic run_vec(input string tag, input logic signed [15:0] v,
                          input logic [6:0] e3, e2, e1, e0);
      int w;
      @(negedge in_clk);
      value = v;
      w = 0;
      @(negedge in_clk);
      chk({tag, "_busy_rise"}, {31'd0, busy}, 1);
      while (busy && w < 40) begin
         @(negedge in_clk);
         w++;
      end
      chk({tag, "_busy_len"}, w, 16);
      scan(tag, e3, e2, e1, e0);
   endtask

   initial begin
      int w;
      logic [6:0] c42 [4];
      c42 = '{D2, D4, BL, BL};

      reset = 1'b1;
      value = '0;
      repeat (3) @(negedge in_clk);
      chk("rst_an", {28'd0, an}, 4'b1111);
      chk("rst_seg", {25'd0, seg}, BL);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_dp", {31'd0, dp}, 1);
      reset = 1'b0;
      @(negedge in_clk);
      chk("first_an", {28'd0, an}, 4'b1110);
      chk("first_seg", {25'd0, seg}, BL);
      chk("first_busy", {31'd0, busy}, 1);
      repeat (20) @(negedge in_clk);
      scan("zero", BL, BL, BL, D0);

      run_vec("v1234",  16'sd1234,  D1, D2, D3, D4);
      run_vec("vm5",    -16'sd5,    BL, BL, MI, 7'h12);
      run_vec("v10000", 16'sd10000, EE, MI, MI, MI);
      run_vec("vm1000", -16'sd1000, EE, MI, MI, MI);
      run_vec("vm999",  -16'sd999,  MI, D9, D9, D9);
      run_vec("v9999",  16'sd9999,  D9, D9, D9, D9);
      run_vec("vmin",   16'sh8000,  EE, MI, MI, MI);
      run_vec("v100",   16'sd100,   BL, D1, D0, D0);

      // 42 then 7 arriving on the fifth conversion step
      @(negedge in_clk);
      value = 16'sd42;
      @(negedge in_clk);
      chk("mid_busy_rise", {31'd0, busy}, 1);
      repeat (5) @(negedge in_clk);
      value = 16'sd7;
      w = 5;
      while (busy && w < 40) begin
         @(negedge in_clk);
         w++;
      end
      chk("mid_busy_len", w, 16);
      for (int k = 1; k <= 17; k++) begin
         @(negedge in_clk);
         chk($sformatf("mid_busy_%0d", k), {31'd0, busy}, (k <= 16) ? 1 : 0);
         chk($sformatf("mid_hold42_%0d", k), {25'd0, seg}, {25'd0, c42[an_idx(an)]});
      end
      scan("seven", BL, BL, BL, D7);

      // reset in the middle of converting 999
      @(negedge in_clk);
      value = 16'sd999;
      @(negedge in_clk);
      repeat (3) @(negedge in_clk);
      #2 reset = 1'b1;
      #1;
      chk("mrst_an", {28'd0, an}, 4'b1111);
      chk("mrst_seg", {25'd0, seg}, BL);
      chk("mrst_busy", {31'd0, busy}, 0);
      repeat (2) @(negedge in_clk);
      reset = 1'b0;
      @(negedge in_clk);
      chk("mrst_first_an", {28'd0, an}, 4'b1110);
      chk("mrst_first_seg", {25'd0, seg}, BL);
      repeat (18) @(negedge in_clk);
      scan("r999", BL, D9, D9, D9);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
